// File: rtl/rv32i_pkg.sv
// Shared timer definitions: register offsets, CTRL layout, byte-merge helper.
package rv32i_pkg;

   localparam logic [3:0] TIMER_CTRL_OFS   = 4'h0;
   localparam logic [3:0] TIMER_COUNT_OFS  = 4'h4;
   localparam logic [3:0] TIMER_CMP_OFS    = 4'h8;
   localparam logic [3:0] TIMER_STATUS_OFS = 4'hC;

   localparam int CTRL_EN_BIT       = 0;
   localparam int CTRL_AUTO_RLD_BIT = 1;
   localparam int CTRL_IRQ_EN_BIT   = 2;
   localparam int CTRL_PSC_LSB      = 8;
   localparam int STATUS_MATCH_BIT  = 0;
   localparam int PSC_W_MAX         = 8;

   typedef struct packed {
      logic [PSC_W_MAX-1:0] psc;
      logic                 irq_en;
      logic                 auto_rld;
      logic                 en;
   } timer_ctrl_t;

   function automatic logic [31:0] bmerge(
      input logic [31:0] old,
      input logic [31:0] wd,
      input logic [3:0]  be
   );
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/lsu_timer_prescaler.sv
// Tick generator for lsu_timer; divides by PSC+1 when LSU_TIMER_PRESCALE_EN
// is defined, otherwise tick simply follows EN.
module lsu_timer_prescaler
   import rv32i_pkg::*;
#(
   parameter int unsigned PSC_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             en,
   input  logic [PSC_W-1:0] psc,
   input  logic             clr,
   output logic             tick
);

`ifdef LSU_TIMER_PRESCALE_EN
   logic [PSC_W-1:0] cnt;

   assign tick = en && (cnt == psc);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == psc) ? '0 : cnt + 1'b1;
   end
`else
   logic unused_psc;

   assign unused_psc = ^{i_clk, i_rst_n, psc, clr};
   assign tick       = en;
`endif

endmodule

// File: rtl/lsu_timer.sv
// Memory-mapped 32-bit timer on the LSU timer window.
// Optional prescaler enabled by LSU_TIMER_PRESCALE_EN.
module lsu_timer
   import rv32i_pkg::*;
#(
   parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF,
   parameter int unsigned PSC_W   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_vld,
   input  logic        i_wren,
   input  logic [3:0]  i_addr,
   input  logic [3:0]  i_bmask,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_rvalid,
   output logic        o_irq
);

   timer_ctrl_t ctrl;
   logic [31:0] count;
   logic [31:0] cmp;
   logic        status;
   logic        tick;
   logic        match;
   logic [31:0] count_tick;
   logic [31:0] rd_val;
   logic        wr, rd;
   logic        wr_ctrl, wr_count, wr_cmp, wr_status;
   logic        w1c;
   logic        unused_addr;

   assign unused_addr = ^i_addr[1:0];

   assign wr        = i_vld & i_wren;
   assign rd        = i_vld & ~i_wren;
   assign wr_ctrl   = wr && (i_addr[3:2] == TIMER_CTRL_OFS[3:2]);
   assign wr_count  = wr && (i_addr[3:2] == TIMER_COUNT_OFS[3:2]);
   assign wr_cmp    = wr && (i_addr[3:2] == TIMER_CMP_OFS[3:2]);
   assign wr_status = wr && (i_addr[3:2] == TIMER_STATUS_OFS[3:2]);
   assign w1c       = wr_status & i_bmask[0] & i_wdata[STATUS_MATCH_BIT];

   lsu_timer_prescaler #(
      .PSC_W (PSC_W)
   ) u_psc (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .en      (ctrl.en),
      .psc     (ctrl.psc[PSC_W-1:0]),
      .clr     (wr_ctrl),
      .tick    (tick)
   );

   assign match = tick && (count == cmp);

   always_comb begin
      count_tick = count;
      if (tick)
         count_tick = (match && ctrl.auto_rld) ? '0 : count + 32'd1;
   end

   always_comb begin
      rd_val = '0;
      unique case (i_addr[3:2])
         2'd0: begin
            rd_val[CTRL_EN_BIT]       = ctrl.en;
            rd_val[CTRL_AUTO_RLD_BIT] = ctrl.auto_rld;
            rd_val[CTRL_IRQ_EN_BIT]   = ctrl.irq_en;
            rd_val[CTRL_PSC_LSB +: PSC_W_MAX] = ctrl.psc;
         end
         2'd1: rd_val = count;
         2'd2: rd_val = cmp;
         2'd3: rd_val[STATUS_MATCH_BIT] = status;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ctrl     <= '0;
         count    <= '0;
         cmp      <= CMP_RST;
         status   <= 1'b0;
         o_rdata  <= '0;
         o_rvalid <= 1'b0;
      end else begin
         o_rvalid <= rd;
         if (rd)
            o_rdata <= rd_val;
         if (wr_ctrl && i_bmask[0]) begin
            ctrl.en       <= i_wdata[CTRL_EN_BIT];
            ctrl.auto_rld <= i_wdata[CTRL_AUTO_RLD_BIT];
            ctrl.irq_en   <= i_wdata[CTRL_IRQ_EN_BIT];
         end
`ifdef LSU_TIMER_PRESCALE_EN
         if (wr_ctrl && i_bmask[1])
            ctrl.psc <= i_wdata[CTRL_PSC_LSB +: PSC_W_MAX];
`endif
         // Written bytes override the ticked value; the rest keep counting.
         count  <= wr_count ? bmerge(count_tick, i_wdata, i_bmask)
                            : count_tick;
         if (wr_cmp)
            cmp <= bmerge(cmp, i_wdata, i_bmask);
         status <= match | (status & ~w1c);
      end
   end

   assign o_irq = status & ctrl.irq_en;

endmodule
